bcd_countdown_timer: RTL and testbench

- Downstream consumer of the team's 1 Hz slow-clock divider.
- Samples the divider's slow_clk output in the clk domain and turns each rising edge into a one-cycle tick.
- Runs a two-digit BCD seconds countdown under a start/pause/load control FSM.
- Drives two seven-segment displays and flags expiry for the lab's top-level game logic.

---
 rtl/bcd_countdown_timer.sv | 171 +++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// -----------------------------------------------------------------------------
// bcd_countdown_timer
//
// Two-digit BCD seconds countdown driven by the 1 Hz slow-clock divider.
// The divider output is sampled in the clk domain through two flops and every
// rising edge becomes a one-cycle tick.  A small control FSM handles
// load / start / pause and stops at 00 with an expiry flag and pulse.
//
// Handshake: load, start and pause are single-cycle strobes sampled on the
// rising edge of clk; there is no back-pressure.  The per-cycle priority is
// load > pause > start > tick.
//
// Ports
//   clk            system clock (same clock as the divider)
//   reset          asynchronous, active-high
//   slow_clk       divider output, sampled as data only
//   load           strobe: load load_tens/load_ones (clamped to 9), go IDLE
//   load_tens      BCD tens value to load
//   load_ones      BCD ones value to load
//   start          strobe: IDLE/PAUSE -> RUN when the count is not 00
//   pause          strobe: RUN -> PAUSE
//   tens, ones     current BCD digits
//   seg_tens       seven-segment pattern for tens (bit0=a ... bit6=g)
//   seg_ones       seven-segment pattern for ones
//   running        high while in RUN
//   expired        high while in EXPIRED
//   expired_pulse  one-cycle pulse on entry to EXPIRED
// -----------------------------------------------------------------------------
module bcd_countdown_timer #(
    parameter logic [3:0] INIT_TENS      = 4'd3,
    parameter logic [3:0] INIT_ONES      = 4'd0,
    parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       running,
    output logic       expired,
    output logic       expired_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t state;

    logic s1;
    logic s2;
    logic tick;
    logic count_zero;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00; // blank
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    // Two-flop sampler of the divider output; clearing these on reset means
    // no tick that was in flight survives a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= slow_clk;
            s2 <= s1;
        end
    end

    // Rising-edge detect; falling edges of slow_clk produce nothing.
    assign tick       = s1 & ~s2;
    assign count_zero = (tens == 4'd0) && (ones == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tens          <= INIT_TENS;
            ones          <= INIT_ONES;
            running       <= 1'b0;
            expired       <= 1'b0;
            expired_pulse <= 1'b0;
        end else begin
            expired_pulse <= 1'b0;
            if (load) begin
                // Load wins over everything, including a coincident tick.
                tens    <= clamp_bcd(load_tens);
                ones    <= clamp_bcd(load_ones);
                state   <= IDLE;
                running <= 1'b0;
                expired <= 1'b0;
            end else begin
                case (state)
                    IDLE, PAUSE: begin
                        if (start && !count_zero) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            // Pause swallows a tick arriving in the same cycle.
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            if (count_zero) begin
                                // Not reachable through start; kept so the
                                // counter can never wrap to 99.
                                state         <= EXPIRED;
                                running       <= 1'b0;
                                expired       <= 1'b1;
                                expired_pulse <= 1'b1;
                            end else if (ones != 4'd0) begin
                                ones <= ones - 4'd1;
                                if (tens == 4'd0 && ones == 4'd1) begin
                                    state         <= EXPIRED;
                                    running       <= 1'b0;
                                    expired       <= 1'b1;
                                    expired_pulse <= 1'b1;
                                end
                            end else begin
                                ones <= 4'd9;
                                tens <= tens - 4'd1;
                            end
                        end
                    end
                    EXPIRED: begin
                        // Held at 00 until the next load.
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        expired <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign seg_tens = seg_decode(tens);
    assign seg_ones = seg_decode(ones);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

  logic       clk;
  logic       reset;
  logic       slow_clk;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       running;
  logic       expired;
  logic       expired_pulse;

  bcd_countdown_timer dut (
    .clk           (clk),
    .reset         (reset),
    .slow_clk      (slow_clk),
    .load          (load),
    .load_tens     (load_tens),
    .load_ones     (load_ones),
    .start         (start),
    .pause         (pause),
    .tens          (tens),
    .ones          (ones),
    .seg_tens      (seg_tens),
    .seg_ones      (seg_ones),
    .running       (running),
    .expired       (expired),
    .expired_pulse (expired_pulse)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // record = {tens, ones, running, expired, expired_pulse}
  logic [10:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  // Active-high gfedcba patterns; default build is active-low so they get inverted.
  logic [6:0] seg_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic [3:0] cur_t;
  logic [3:0] cur_o;
  logic       cur_r;
  logic       cur_e;

  task automatic expect_now(input logic p);
    exp_q.push_back({cur_t, cur_o, cur_r, cur_e, p});
  endtask

  task automatic check_pop(input string name);
    logic [10:0] e;
    logic [10:0] a;
    logic [6:0]  es_t;
    logic [6:0]  es_o;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      a = {tens, ones, running, expired, expired_pulse};
      es_t = (e[10:7] <= 4'd9) ? ~seg_hi[e[10:7]] : 7'h7F;
      es_o = (e[6:3]  <= 4'd9) ? ~seg_hi[e[6:3]]  : 7'h7F;
      if (a !== e || seg_tens !== es_t || seg_ones !== es_o) begin
        n_fail++;
        $display("FAIL %s: got t=%0d o=%0d run=%b exp=%b pulse=%b seg=%h/%h, want t=%0d o=%0d run=%b exp=%b pulse=%b seg=%h/%h",
                 name, a[10:7], a[6:3], a[2], a[1], a[0], seg_tens, seg_ones,
                 e[10:7], e[6:3], e[2], e[1], e[0], es_t, es_o);
      end
    end
  endtask

  // Advance one clock and check at the following falling edge.
  task automatic step(input string name);
    @(posedge clk);
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    check_pop(name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                       input logic st, input logic pa,
                       input logic [3:0] et, input logic [3:0] eo,
                       input logic er, input logic ee, input logic ep,
                       input string name);
    load = ld; load_tens = lt; load_ones = lo; start = st; pause = pa;
    cur_t = et; cur_o = eo; cur_r = er; cur_e = ee;
    expect_now(ep);
    step(name);
  endtask

  // One slow_clk period: rise, count checked unchanged after the first edge,
  // new value after the second edge, then a falling edge that must do nothing.
  task automatic slow_tick(input logic [3:0] nt, input logic [3:0] no,
                           input logic nr, input logic ne, input logic np,
                           input string name);
    slow_clk = 1'b1;
    expect_now(1'b0);
    step({name, "_sync"});
    cur_t = nt; cur_o = no; cur_r = nr; cur_e = ne;
    expect_now(np);
    step(name);
    slow_clk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_now(1'b0);
      step({name, "_fall"});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ld;
    logic [3:0] lt;
    logic [3:0] lo;
    logic       st;
    logic       pa;
    logic [3:0] et;
    logic [3:0] eo;
    logic       er;
    logic       ee;
    logic       ep;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0}; // load 12
    vecs[1]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0}; // start
    vecs[2]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0}; // pause
    vecs[3]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0}; // pause in PAUSE
    vecs[4]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0}; // resume
    vecs[5]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0}; // start in RUN
    vecs[6]  = '{1'b1, 4'hC, 4'hA, 1'b0, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0}; // clamp 99
    vecs[7]  = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}; // load 00
    vecs[8]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0}; // start at 00
    vecs[9]  = '{1'b1, 4'd4, 4'd5, 1'b0, 1'b0, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0}; // load 45
    vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0}; // start
    vecs[11] = '{1'b1, 4'd9, 4'hF, 1'b0, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0}; // load in RUN
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1; slow_clk = 1'b0; load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
    start = 1'b0; pause = 1'b0;
    cur_t = 4'd3; cur_o = 4'd0; cur_r = 1'b0; cur_e = 1'b0;
    repeat (2) @(negedge clk);
    expect_now(1'b0);
    check_pop("reset_state");
    reset = 1'b0;
    expect_now(1'b0);
    step("reset_release");

    // table-driven control vectors
    for (int i = 0; i < 12; i++)
      apply(vecs[i].ld, vecs[i].lt, vecs[i].lo, vecs[i].st, vecs[i].pa,
            vecs[i].et, vecs[i].eo, vecs[i].er, vecs[i].ee, vecs[i].ep,
            $sformatf("vec%0d", i));

    // count 12 -> 11 -> 10 -> 09
    apply(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, "load12");
    apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, "start12");
    slow_tick(4'd1, 4'd1, 1'b1, 1'b0, 1'b0, "dec_11");
    slow_tick(4'd1, 4'd0, 1'b1, 1'b0, 1'b0, "dec_10");
    slow_tick(4'd0, 4'd9, 1'b1, 1'b0, 1'b0, "dec_09");

    // expiry
    apply(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, "load02");
    apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, "start02");
    slow_tick(4'd0, 4'd1, 1'b1, 1'b0, 1'b0, "dec_01");
    slow_tick(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "dec_00_expire");
    slow_tick(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "tick_in_expired");
    apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "start_in_expired");
    apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "pause_in_expired");
    apply(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, "load05_after_exp");

    // pause coincident with tick at 45
    apply(1'b1, 4'd4, 4'd5, 1'b0, 1'b0, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0, "load45");
    apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, "start45");
    slow_clk = 1'b1;
    expect_now(1'b0);
    step("pause_tick_sync");
    pause = 1'b1;               // tick is high during this cycle
    cur_r = 1'b0;
    expect_now(1'b0);
    step("pause_with_tick");
    slow_clk = 1'b0;
    expect_now(1'b0);
    step("pause_tick_fall");
    slow_tick(4'd4, 4'd5, 1'b0, 1'b0, 1'b0, "tick_in_pause");
    apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, "resume45");
    slow_tick(4'd4, 4'd4, 1'b1, 1'b0, 1'b0, "dec_44");

    // load coincident with tick
    slow_clk = 1'b1;
    expect_now(1'b0);
    step("load_tick_sync");
    load = 1'b1; load_tens = 4'd3; load_ones = 4'd3;
    cur_t = 4'd3; cur_o = 4'd3; cur_r = 1'b0;
    expect_now(1'b0);
    step("load_with_tick");
    slow_clk = 1'b0;
    expect_now(1'b0);
    step("load_tick_fall");
    slow_tick(4'd3, 4'd3, 1'b0, 1'b0, 1'b0, "tick_in_idle");

    // asynchronous reset mid-cycle while running at 27 with a tick pending
    apply(1'b1, 4'd2, 4'd7, 1'b0, 1'b0, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0, "load27");
    apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2, 4'd7, 1'b1, 1'b0, 1'b0, "start27");
    slow_clk = 1'b1;
    expect_now(1'b0);
    step("reset_tick_sync");
    #1 reset = 1'b1;
    #1;
    cur_t = 4'd3; cur_o = 4'd0; cur_r = 1'b0; cur_e = 1'b0;
    expect_now(1'b0);
    check_pop("async_reset");
    #1 reset = 1'b0;
    slow_clk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_now(1'b0);
      step("after_reset_hold");
    end
    slow_tick(4'd3, 4'd0, 1'b0, 1'b0, 1'b0, "after_reset_edge");

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected records never checked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
